// File: rtl/lcd_timing_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_timing_ctrl
// Scan-timing sequencer for the LCD/PPU. It owns the dot and line counters,
// derives the STAT mode (2 OAM search, 3 transfer, 0 HBlank, 1 VBlank), and
// generates the LY/LYC coincidence flag, the VBlank and STAT interrupt pulses
// and the line/frame strobes for the pixel fetcher. It also arbitrates OAM and
// VRAM between the CPU and the PPU from the current mode.
//
// Optional build macro: LCD_STAT_BLOCKING_EN
//   defined   : stat_irq fires only on a rising edge of the OR of all enabled
//               STAT sources (a source rising while another is high is hidden).
//   undefined : stat_irq fires whenever any individual source rises.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   dot_en              one pulse per dot
//   lcd_enable          LCDC.LCDEnable, sampled every clk
//   lyc[7:0]            LY compare value
//   stat_ie[3:0]        [0] mode0, [1] mode1, [2] mode2, [3] coincidence
//   cpu_oam_req/vram    CPU access requests
//   ly, dot, mode       current line, dot within line, STAT mode
//   coincidence         registered ly == lyc
//   vblank_irq/stat_irq one-clk interrupt pulses
//   line_start          one-clk pulse at dot 0 of each visible line
//   frame_start         one-clk pulse at line 0 dot 0
//   cpu_*_gnt           CPU access granted (combinational)
//   ppu_*_sel           memory owned by the PPU (combinational)
// -----------------------------------------------------------------------------
module lcd_timing_ctrl #(
  parameter logic [8:0] DOTS_PER_LINE = 9'd456,
  parameter logic [7:0] VISIBLE_LINES = 8'd144,
  parameter logic [7:0] TOTAL_LINES   = 8'd154,
  parameter logic [8:0] OAM_DOTS      = 9'd80,
  parameter logic [8:0] XFER_DOTS     = 9'd172
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  input  logic       cpu_oam_req,
  input  logic       cpu_vram_req,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic [1:0] mode,
  output logic       coincidence,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       line_start,
  output logic       frame_start,
  output logic       cpu_oam_gnt,
  output logic       cpu_vram_gnt,
  output logic       ppu_oam_sel,
  output logic       ppu_vram_sel
);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam logic [8:0] LAST_DOT  = DOTS_PER_LINE - 9'd1;
  localparam logic [7:0] LAST_LINE = TOTAL_LINES - 8'd1;
  localparam logic [8:0] XFER_END  = OAM_DOTS + XFER_DOTS;

  logic       running_q, running_d;
  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic [1:0] mode_q, mode_d;
  logic       coinc_q, coinc_d;
  logic       vblank_irq_q, vblank_irq_d;
  logic       stat_irq_q, stat_irq_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  // STAT source vector of the registered state; doubles as the edge detector.
  logic [3:0] src_q, src_d;

  // Mode as a pure function of a (line, dot) position.
  function automatic logic [1:0] mode_decode(input logic [7:0] l, input logic [8:0] d);
    logic [1:0] m;
    if (l >= VISIBLE_LINES) begin
      m = MODE_VBLANK;
    end else if (d < OAM_DOTS) begin
      m = MODE_OAM;
    end else if (d < XFER_END) begin
      m = MODE_XFER;
    end else begin
      m = MODE_HBLANK;
    end
    return m;
  endfunction

  // Next-state for counters, mode, flags and pulses.
  always_comb begin
    running_d     = running_q;
    dot_d         = dot_q;
    ly_d          = ly_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (!lcd_enable) begin
      running_d = 1'b0;
      dot_d     = 9'd0;
      ly_d      = 8'd0;
    end else if (!running_q) begin
      // Start-up cycle: counters stay at (0,0) and both strobes fire.
      running_d     = 1'b1;
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (dot_en) begin
      if (dot_q == LAST_DOT) begin
        dot_d = 9'd0;
        if (ly_q == LAST_LINE) begin
          ly_d = 8'd0;
        end else begin
          ly_d = ly_q + 8'd1;
        end
        line_start_d  = (ly_d < VISIBLE_LINES);
        frame_start_d = (ly_d == 8'd0);
      end else begin
        dot_d = dot_q + 9'd1;
      end
    end else begin
      running_d = running_q;
    end

    // Mode/coincidence registers carry the decode of the next counter values.
    mode_d  = running_d ? mode_decode(ly_d, dot_d) : MODE_HBLANK;
    coinc_d = running_d & (ly_d == lyc);

    // Mode 1 is only ever entered by the wrap into the first VBlank line.
    vblank_irq_d = running_q & running_d & (mode_d == MODE_VBLANK) & (mode_q != MODE_VBLANK);

    if (running_d) begin
      src_d = {stat_ie[3] & coinc_d,
               stat_ie[2] & (mode_d == MODE_OAM),
               stat_ie[1] & (mode_d == MODE_VBLANK),
               stat_ie[0] & (mode_d == MODE_HBLANK)};
    end else begin
      src_d = 4'b0000;
    end

`ifdef LCD_STAT_BLOCKING_EN
    stat_irq_d = (|src_d) & ~(|src_q);
`else
    stat_irq_d = |(src_d & ~src_q);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q     <= 1'b0;
      dot_q         <= 9'd0;
      ly_q          <= 8'd0;
      mode_q        <= MODE_HBLANK;
      coinc_q       <= 1'b0;
      vblank_irq_q  <= 1'b0;
      stat_irq_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      src_q         <= 4'b0000;
    end else begin
      running_q     <= running_d;
      dot_q         <= dot_d;
      ly_q          <= ly_d;
      mode_q        <= mode_d;
      coinc_q       <= coinc_d;
      vblank_irq_q  <= vblank_irq_d;
      stat_irq_q    <= stat_irq_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      src_q         <= src_d;
    end
  end

  assign ly          = ly_q;
  assign dot         = dot_q;
  assign mode        = mode_q;
  assign coincidence = coinc_q;
  assign vblank_irq  = vblank_irq_q;
  assign stat_irq    = stat_irq_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  // Memory ownership follows the registered mode; grants drop in the same
  // cycle the lock begins, with no queuing of held requests.
  assign ppu_oam_sel  = running_q & ((mode_q == MODE_OAM) | (mode_q == MODE_XFER));
  assign ppu_vram_sel = running_q & (mode_q == MODE_XFER);
  assign cpu_oam_gnt  = cpu_oam_req & ~ppu_oam_sel;
  assign cpu_vram_gnt = cpu_vram_req & ~ppu_vram_sel;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Testbench for lcd_timing_ctrl: directed stimulus pushes hand-computed
// expectations (tagged with the cycle they apply to) into a scoreboard queue;
// a monitor samples the DUT 1 ns after each rising edge and compares.
module tb_lcd_timing_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dot_en;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic       cpu_oam_req;
  logic       cpu_vram_req;
  logic [7:0] ly;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       coincidence;
  logic       vblank_irq;
  logic       stat_irq;
  logic       line_start;
  logic       frame_start;
  logic       cpu_oam_gnt;
  logic       cpu_vram_gnt;
  logic       ppu_oam_sel;
  logic       ppu_vram_sel;

  lcd_timing_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dot_en       (dot_en),
    .lcd_enable   (lcd_enable),
    .lyc          (lyc),
    .stat_ie      (stat_ie),
    .cpu_oam_req  (cpu_oam_req),
    .cpu_vram_req (cpu_vram_req),
    .ly           (ly),
    .dot          (dot),
    .mode         (mode),
    .coincidence  (coincidence),
    .vblank_irq   (vblank_irq),
    .stat_irq     (stat_irq),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .cpu_oam_gnt  (cpu_oam_gnt),
    .cpu_vram_gnt (cpu_vram_gnt),
    .ppu_oam_sel  (ppu_oam_sel),
    .ppu_vram_sel (ppu_vram_sel)
  );

  always #5 clk = ~clk;

  localparam int F_DOT   = 0;
  localparam int F_LY    = 1;
  localparam int F_MODE  = 2;
  localparam int F_COINC = 3;
  localparam int F_VBI   = 4;
  localparam int F_STI   = 5;
  localparam int F_LS    = 6;
  localparam int F_FS    = 7;
  localparam int F_OGNT  = 8;
  localparam int F_VGNT  = 9;
  localparam int F_OSEL  = 10;
  localparam int F_VSEL  = 11;
  localparam int F_VBCNT = 12;

`ifdef LCD_STAT_BLOCKING_EN
  localparam int STI_AT_OAM_ENTRY = 0;
`else
  localparam int STI_AT_OAM_ENTRY = 1;
`endif

  typedef struct {
    int cyc;
    int sel;
    int exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   vb_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int field(int sel);
    case (sel)
      F_DOT:   return int'(dot);
      F_LY:    return int'(ly);
      F_MODE:  return int'(mode);
      F_COINC: return int'(coincidence);
      F_VBI:   return int'(vblank_irq);
      F_STI:   return int'(stat_irq);
      F_LS:    return int'(line_start);
      F_FS:    return int'(frame_start);
      F_OGNT:  return int'(cpu_oam_gnt);
      F_VGNT:  return int'(cpu_vram_gnt);
      F_OSEL:  return int'(ppu_oam_sel);
      F_VSEL:  return int'(ppu_vram_sel);
      F_VBCNT: return vb_cnt;
      default: return -1;
    endcase
  endfunction

  function automatic string fname(int sel);
    case (sel)
      F_DOT:   return "dot";
      F_LY:    return "ly";
      F_MODE:  return "mode";
      F_COINC: return "coincidence";
      F_VBI:   return "vblank_irq";
      F_STI:   return "stat_irq";
      F_LS:    return "line_start";
      F_FS:    return "frame_start";
      F_OGNT:  return "cpu_oam_gnt";
      F_VGNT:  return "cpu_vram_gnt";
      F_OSEL:  return "ppu_oam_sel";
      F_VSEL:  return "ppu_vram_sel";
      F_VBCNT: return "vblank_count";
      default: return "unknown";
    endcase
  endfunction

  // Called at a falling edge: the expectation applies after the next rising edge.
  task automatic chk(input int sel, input int exp);
    exp_t e;
    e.cyc = cyc + 1;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Advance to the falling edge just before position n (relative to base).
  task automatic at(input int n);
    while (cyc < base + n - 1) @(negedge clk);
  endtask

  // Monitor: sample after each rising edge and retire due expectations.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(posedge clk);
      #1;
      if (vblank_irq) vb_cnt = vb_cnt + 1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_tests = n_tests + 1;
        if (e.cyc < cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: check for cycle %0d not reached in time (now %0d), required %0d",
                   fname(e.sel), e.cyc, cyc, e.exp);
        end else begin
          act = field(e.sel);
          if (act != e.exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @pos %0d: got %0d, required %0d",
                     fname(e.sel), cyc - base, act, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    lcd_enable   = 1'b0;
    dot_en       = 1'b1;
    lyc          = 8'd200;
    stat_ie      = 4'b0101;
    cpu_oam_req  = 1'b1;
    cpu_vram_req = 1'b1;

    repeat (3) @(negedge clk);
    // Reset state.
    chk(F_DOT, 0); chk(F_LY, 0); chk(F_MODE, 0); chk(F_COINC, 0);
    chk(F_VBI, 0); chk(F_STI, 0); chk(F_LS, 0); chk(F_FS, 0);
    chk(F_OSEL, 0); chk(F_VSEL, 0); chk(F_OGNT, 1); chk(F_VGNT, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Enable: position 0 is the start-up cycle.
    base = cyc + 1;
    lcd_enable = 1'b1;
    chk(F_MODE, 2); chk(F_LS, 1); chk(F_FS, 1); chk(F_DOT, 0); chk(F_LY, 0);
    chk(F_STI, 1); chk(F_OGNT, 0); chk(F_VGNT, 1); chk(F_OSEL, 1); chk(F_VSEL, 0);
    at(1);   chk(F_DOT, 1); chk(F_LS, 0); chk(F_FS, 0); chk(F_MODE, 2); chk(F_STI, 0);
    at(79);  chk(F_MODE, 2); chk(F_VGNT, 1); chk(F_OGNT, 0);
    at(80);  chk(F_MODE, 3); chk(F_VGNT, 0); chk(F_OGNT, 0); chk(F_VSEL, 1);
    at(251); chk(F_MODE, 3); chk(F_VGNT, 0); chk(F_STI, 0);
    at(252); chk(F_MODE, 0); chk(F_OGNT, 1); chk(F_VGNT, 1); chk(F_STI, 1); chk(F_OSEL, 0);
    at(253); chk(F_STI, 0);
    at(455); chk(F_DOT, 455); chk(F_MODE, 0); chk(F_LY, 0);
    at(456); chk(F_LY, 1); chk(F_DOT, 0); chk(F_LS, 1); chk(F_FS, 0); chk(F_MODE, 2);
             chk(F_OGNT, 0); chk(F_STI, STI_AT_OAM_ENTRY);
    at(457); chk(F_STI, 0); chk(F_LS, 0);

    // Coincidence interrupt on line 5.
    at(600);  stat_ie = 4'b1000; lyc = 8'd5; chk(F_STI, 0); chk(F_COINC, 0);
    at(2279); chk(F_LY, 4); chk(F_COINC, 0);
    at(2280); chk(F_LY, 5); chk(F_DOT, 0); chk(F_COINC, 1); chk(F_STI, 1);
    at(2281); chk(F_STI, 0); chk(F_COINC, 1);
    at(2735); chk(F_COINC, 1); chk(F_DOT, 455);
    at(2736); chk(F_COINC, 0); chk(F_LY, 6); chk(F_STI, 0);

    // Mid-frame disable, then re-enable.
    at(3292); stat_ie = 4'b0101; chk(F_LY, 7); chk(F_DOT, 100); chk(F_MODE, 3); chk(F_STI, 0);
    at(3293); lcd_enable = 1'b0;
    chk(F_LY, 0); chk(F_DOT, 0); chk(F_MODE, 0); chk(F_COINC, 0);
    chk(F_OGNT, 1); chk(F_VGNT, 1); chk(F_OSEL, 0); chk(F_VSEL, 0);
    chk(F_LS, 0); chk(F_FS, 0); chk(F_STI, 0); chk(F_VBI, 0);
    at(3295); chk(F_DOT, 0); chk(F_LY, 0); chk(F_MODE, 0); chk(F_STI, 0);
    at(3296); lcd_enable = 1'b1;
    chk(F_MODE, 2); chk(F_FS, 1); chk(F_LS, 1); chk(F_DOT, 0); chk(F_LY, 0); chk(F_STI, 1);
    base = base + 3296;

    // dot_en low holds the counters for three cycles.
    at(1); chk(F_DOT, 1); chk(F_FS, 0);
    at(2); dot_en = 1'b0; chk(F_DOT, 1);
    at(4); chk(F_DOT, 1); chk(F_MODE, 2);
    at(5); dot_en = 1'b1; chk(F_DOT, 2);
    base = base + 3;

    // Full frame: VBlank entry and frame wrap.
    at(65663); chk(F_LY, 143); chk(F_DOT, 455); chk(F_MODE, 0); chk(F_VBI, 0);
    at(65664); chk(F_LY, 144); chk(F_DOT, 0); chk(F_MODE, 1); chk(F_VBI, 1); chk(F_LS, 0);
    at(65665); chk(F_VBI, 0); chk(F_MODE, 1); chk(F_OGNT, 1); chk(F_VGNT, 1); chk(F_OSEL, 0);
    at(70223); chk(F_LY, 153); chk(F_DOT, 455); chk(F_MODE, 1);
    at(70224); chk(F_LY, 0); chk(F_DOT, 0); chk(F_MODE, 2); chk(F_FS, 1); chk(F_LS, 1);
               chk(F_VBI, 0); chk(F_STI, 1); chk(F_VBCNT, 1);
    at(70225); chk(F_FS, 0);

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL %s: check for cycle %0d never retired, required %0d",
               fname(sb[0].sel), sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_timing_ctrl.md
Name: lcd_timing_ctrl

Overview:
- Scan-timing sequencer for the LCD/PPU.
- Owns the dot and line counters and derives the STAT mode (2 OAM search, 3 transfer, 0 HBlank, 1 VBlank).
- Generates the LY/LYC coincidence flag, the VBlank and STAT interrupt pulses, and line/frame strobes for the pixel fetcher.
- Arbitrates OAM and VRAM between the CPU and the PPU according to the current mode.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline.
- VISIBLE_LINES, 144, lines with modes 2/3/0.
- TOTAL_LINES, 154, lines per frame.
- OAM_DOTS, 80, mode 2 length in dots.
- XFER_DOTS, 172, fixed mode 3 length in dots.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- dot_en, input, 1, dot-rate clock enable (one pulse per dot).
- lcd_enable, input, 1, LCDC.LCDEnable.
- lyc, input, 8, LYC compare value.
- stat_ie, input, 4, interrupt enables: [0] mode0, [1] mode1, [2] mode2, [3] coincidence.
- cpu_oam_req, input, 1, CPU requests OAM.
- cpu_vram_req, input, 1, CPU requests VRAM.
- ly, output, 8, current line.
- dot, output, 9, dot within the line.
- mode, output, 2, STAT mode.
- coincidence, output, 1, ly==lyc.
- vblank_irq, output, 1, one-clk pulse.
- stat_irq, output, 1, one-clk pulse.
- line_start, output, 1, one-clk pulse at dot 0 of lines 0..VISIBLE_LINES-1.
- frame_start, output, 1, one-clk pulse at line 0 dot 0.
- cpu_oam_gnt, output, 1, CPU OAM access granted.
- cpu_vram_gnt, output, 1, CPU VRAM access granted.
- ppu_oam_sel, output, 1, OAM owned by the PPU.
- ppu_vram_sel, output, 1, VRAM owned by the PPU.

Behaviour:
- Reset (async, reset_n=0):
  - dot=0, ly=0, mode=0, coincidence=0, all pulses 0, ppu_*_sel=0.
  - Internal `running` flag=0.
- Disabled (lcd_enable=0, sampled each clk):
  - Next clk: dot=0, ly=0, mode=0, coincidence=0, running=0.
  - No pulses; dot_en ignored. Disabling mid-line/mid-frame aborts immediately.
- Enable:
  - First clk with lcd_enable=1 and running=0: running←1, mode←2, line_start=1, frame_start=1.
  - Counters are not advanced on this cycle, regardless of dot_en.
- Advance (running=1, dot_en=1):
  - dot←dot+1.
  - At dot=DOTS_PER_LINE-1: dot←0 and ly←ly+1.
  - At ly=TOTAL_LINES-1 with dot wrap: ly←0.
  - dot_en=0 holds all state.
- Mode: registered, equal to the decode of the next counter values.
  - ly≥VISIBLE_LINES → 1.
  - Else dot<OAM_DOTS → 2.
  - Else dot<OAM_DOTS+XFER_DOTS → 3.
  - Else → 0.
- Strobes:
  - line_start pulses on the cycle ly/dot become (L,0) with L<VISIBLE_LINES.
  - frame_start pulses when they become (0,0).
  - vblank_irq pulses the cycle mode becomes 1 (entry to ly=VISIBLE_LINES). Exactly one per frame.
- coincidence: registered (ly_next==lyc) while running, else 0. An lyc change takes effect next clk.
- stat sources:
  - s0 = stat_ie[0]&mode==0
  - s1 = stat_ie[1]&mode==1
  - s2 = stat_ie[2]&mode==2
  - s3 = stat_ie[3]&coincidence
  - Evaluated on registered values; the edge-detect register clears when not running.
- Arbitration (combinational):
  - ppu_oam_sel = running & (mode==2 | mode==3).
  - ppu_vram_sel = running & mode==3.
  - cpu_oam_gnt = cpu_oam_req & ~ppu_oam_sel.
  - cpu_vram_gnt = cpu_vram_req & ~ppu_vram_sel.
  - A CPU request held across a lock boundary loses its grant in the same cycle the mode changes; there is no queuing.

Optional Feature:
- Macro: LCD_STAT_BLOCKING_EN.
- Defined:
  - stat_line = s0|s1|s2|s3.
  - stat_irq pulses only on a rising edge of stat_line.
  - A source rising while another is already high produces no pulse.
- Undefined:
  - stat_irq pulses on any cycle where any individual source rises (0→1).
  - Multiple same-cycle rises give a single pulse.

Test Plan:
- Reset, lcd_enable=1, dot_en every clk for 456 dots → mode=2 for dots 0-79, 3 for 80-251, 0 for 252-455; then ly=1, dot=0, line_start=1.
- Run to ly=143 dot 455 then one dot → ly=144, mode=1, vblank_irq exactly one clk. From ly=153 dot 455 → ly=0, mode=2, frame_start=1, line_start=1.
- lyc=5, stat_ie=4'b1000 → coincidence rises as ly becomes 5 and stays high 456 dots; stat_irq single pulse.
- cpu_vram_req=cpu_oam_req=1 held over line 0:
  - cpu_oam_gnt=0 dots 0-251, =1 dots 252-455.
  - cpu_vram_gnt=0 dots 80-251, =1 elsewhere.
- lcd_enable→0 at ly=50 dot 100 → next clk ly=0, dot=0, mode=0, both gnt follow req, no pulses. Re-enable → mode=2, frame_start=1, counters hold one cycle.
- stat_ie=4'b0101, run through the line 0→1 HBlank-to-OAM boundary:
  - With LCD_STAT_BLOCKING_EN: no stat_irq at mode 2 entry (line stays high).
  - Without LCD_STAT_BLOCKING_EN: stat_irq pulses at mode 2 entry.
  - Both builds pulse at mode 0 entry on dot 252.
